// File: rtl/pop_sequence_controller_pkg.sv
// pop_ctrl_pkg: shared types and constants for the POP front-panel controller.
//   - mode encodings (mode_e) and the mode step order
//   - default register widths, reset values and saturation limits
//   - button index map and the auto-repeat enable mask
//   - pins_t: the registered output pin bundle
package pop_ctrl_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_LASER_SETUP = 3'd0,
    MODE_POP         = 3'd1,
    MODE_DARK        = 3'd2,
    MODE_PUMP_CAL    = 3'd3,
    MODE_DR          = 3'd4
  } mode_e;

  localparam int DEF_PIE_W        = 8;
  localparam int DEF_FREE_W       = 12;
  localparam int DEF_PIE_DEFAULT  = 25;
  localparam int DEF_FREE_DEFAULT = 250;
  localparam int DEF_PIE_MIN      = 1;
  localparam int DEF_PIE_MAX      = 255;
  localparam int DEF_FREE_MIN     = 1;
  localparam int DEF_FREE_MAX     = 4095;
  localparam int DEF_DEB_COUNT    = 4;
  localparam int DEF_REPEAT_TICKS = 2000;

  // Button slots in the packed button vectors.
  localparam int NUM_BTN  = 6;
  localparam int BTN_MODE = 0;
  localparam int BTN_DEF  = 1;
  localparam int BTN_TL   = 2;
  localparam int BTN_TR   = 3;
  localparam int BTN_BL   = 4;
  localparam int BTN_BR   = 5;

  // Only the four adjust buttons auto-repeat.
  localparam logic [NUM_BTN-1:0] REPEAT_MASK = 6'b111100;

  typedef struct packed {
    logic led;
    logic pump;
    logic probe;
    logic mw;
    logic sample;
  } pins_t;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_LASER_SETUP: return MODE_POP;
      MODE_POP:         return MODE_DARK;
      MODE_DARK:        return MODE_PUMP_CAL;
      MODE_PUMP_CAL:    return MODE_DR;
      default:          return MODE_LASER_SETUP;
    endcase
  endfunction

  // True when stepping out of m enters or leaves MODE_POP.
  function automatic logic touches_pop(input mode_e m);
    return (m == MODE_LASER_SETUP) || (m == MODE_POP);
  endfunction

endpackage

// File: rtl/pop_sequence_controller_if.sv
// pop_ctrl_if: front-panel / timer / pin bundle of the POP controller.
//   master: panel and timer side (drives buttons, tick, timer raw signals,
//           blink sources; observes mode, lengths, cfg_update and pins)
//   slave : the controller itself
interface pop_ctrl_if
  import pop_ctrl_pkg::*;
#(
  parameter int PIE_W  = DEF_PIE_W,
  parameter int FREE_W = DEF_FREE_W
);
  logic              tick_100us;
  logic              mode_btn_n, defaults_btn_n;
  logic              tl_btn_n, tr_btn_n, bl_btn_n, br_btn_n;
  logic              pump_in, probe_in, mw_in, sample_in;
  logic              slow_pulse, fast_pulse;
  logic [MODE_W-1:0] mode;
  logic [PIE_W-1:0]  pie_len;
  logic [FREE_W-1:0] free_len;
  logic              cfg_update;
  logic              led, pump_out, probe_out, mw_out, sample_out;

  modport master (
    output tick_100us, mode_btn_n, defaults_btn_n, tl_btn_n, tr_btn_n, bl_btn_n, br_btn_n,
    output pump_in, probe_in, mw_in, sample_in, slow_pulse, fast_pulse,
    input  mode, pie_len, free_len, cfg_update, led, pump_out, probe_out, mw_out, sample_out
  );

  modport slave (
    input  tick_100us, mode_btn_n, defaults_btn_n, tl_btn_n, tr_btn_n, bl_btn_n, br_btn_n,
    input  pump_in, probe_in, mw_in, sample_in, slow_pulse, fast_pulse,
    output mode, pie_len, free_len, cfg_update, led, pump_out, probe_out, mw_out, sample_out
  );
endinterface

// File: rtl/pop_sequence_controller_button_debounce.sv
// button_debounce: one active-low push button.
//   clk, rst   : system clock, synchronous active-high reset
//   tick       : sampling strobe; raw level is only looked at on this strobe
//   raw_n      : raw button, low = pressed (asynchronous, synchronised here)
//   pressed    : debounced level
//   press      : one-clk pulse on accepted released->pressed
//   rpt        : one-clk auto-repeat pulse (REPEAT_EN only): REPEAT_TICKS
//                ticks after the accepted press, then every REPEAT_TICKS/4
module button_debounce #(
  parameter int DEB_COUNT    = 4,
  parameter int REPEAT_TICKS = 2000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw_n,
  output logic pressed,
  output logic press,
  output logic rpt
);
  localparam int DW         = $clog2(DEB_COUNT + 1);
  localparam int RW         = $clog2(REPEAT_TICKS + 1);
  localparam int RPT_RELOAD = REPEAT_TICKS - REPEAT_TICKS / 4;

  logic [1:0]    sync_n;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rpt_cnt;
  logic          raw_p, flip;

  assign raw_p = ~sync_n[1];
  // Last of DEB_COUNT consecutive differing samples: state flips this tick.
  assign flip  = tick && (raw_p != pressed) && (deb_cnt == DW'(DEB_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_n  <= 2'b11;
      deb_cnt <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
      rpt     <= 1'b0;
      rpt_cnt <= '0;
    end else begin
      sync_n <= {sync_n[0], raw_n};
      press  <= flip && !pressed;
      rpt    <= 1'b0;
      if (tick) begin
        if (raw_p == pressed) begin
          deb_cnt <= '0;
        end else if (flip) begin
          deb_cnt <= '0;
          pressed <= raw_p;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
      // Repeat count restarts at the accept tick and is cleared on release,
      // so a release tick never fires a repeat.
      if (!REPEAT_EN || !pressed || flip) begin
        rpt_cnt <= '0;
      end else if (tick) begin
        if (rpt_cnt == RW'(REPEAT_TICKS - 1)) begin
          rpt     <= 1'b1;
          rpt_cnt <= RW'(RPT_RELOAD);
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pop_sequence_controller.sv
// pop_sequence_controller: front panel and mode controller for the POP chain.
//   clk : 2.5 MHz system clock      rst : synchronous reset, active-high
//   bus : pop_ctrl_if.slave -- buttons, tick_100us, timer raw signals,
//         blink sources in; mode, pie_len, free_len, cfg_update and the
//         registered led/pump/probe/mw/sample pin drivers out.
// Optional: define POP_CYCLE_SYNC_EN to hold mode changes that enter or
// leave MODE_POP until the POP timer outputs are all idle.
module pop_sequence_controller
  import pop_ctrl_pkg::*;
#(
  parameter int PIE_W        = DEF_PIE_W,
  parameter int FREE_W       = DEF_FREE_W,
  parameter int PIE_DEFAULT  = DEF_PIE_DEFAULT,
  parameter int FREE_DEFAULT = DEF_FREE_DEFAULT,
  parameter int PIE_MIN      = DEF_PIE_MIN,
  parameter int PIE_MAX      = DEF_PIE_MAX,
  parameter int FREE_MIN     = DEF_FREE_MIN,
  parameter int FREE_MAX     = DEF_FREE_MAX,
  parameter int DEB_COUNT    = DEF_DEB_COUNT,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input logic     clk,
  input logic     rst,
  pop_ctrl_if.slave bus
);
  logic [NUM_BTN-1:0] raw_n, btn_press, btn_rpt, btn_evt, btn_level_unused;

  assign raw_n = {bus.br_btn_n, bus.bl_btn_n, bus.tr_btn_n,
                  bus.tl_btn_n, bus.defaults_btn_n, bus.mode_btn_n};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEB_COUNT   (DEB_COUNT),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .tick   (bus.tick_100us),
      .raw_n  (raw_n[i]),
      .pressed(btn_level_unused[i]),
      .press  (btn_press[i]),
      .rpt    (btn_rpt[i])
    );
  end

  assign btn_evt = btn_press | btn_rpt;

  // ---------------- mode FSM ----------------
  mode_e mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (rst) mode_q <= MODE_LASER_SETUP;
    else     mode_q <= mode_d;
  end

`ifdef POP_CYCLE_SYNC_EN
  logic pend_q, pend_d, timer_idle;

  assign timer_idle = ~(bus.pump_in | bus.probe_in | bus.mw_in | bus.sample_in);

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  // A pending change swallows further mode presses until it commits.
  always_comb begin
    mode_d = mode_q;
    pend_d = pend_q;
    if (pend_q) begin
      if (timer_idle) begin
        mode_d = next_mode(mode_q);
        pend_d = 1'b0;
      end
    end else if (btn_press[BTN_MODE]) begin
      if (touches_pop(mode_q) && !timer_idle) pend_d = 1'b1;
      else                                    mode_d = next_mode(mode_q);
    end
  end
`else
  always_comb begin
    mode_d = mode_q;
    if (btn_press[BTN_MODE]) mode_d = next_mode(mode_q);
  end
`endif

  // ---------------- timing registers ----------------
  localparam logic [PIE_W-1:0]  PIE_DEF_V  = PIE_W'(PIE_DEFAULT);
  localparam logic [PIE_W-1:0]  PIE_MIN_V  = PIE_W'(PIE_MIN);
  localparam logic [PIE_W-1:0]  PIE_MAX_V  = PIE_W'(PIE_MAX);
  localparam logic [FREE_W-1:0] FREE_DEF_V = FREE_W'(FREE_DEFAULT);
  localparam logic [FREE_W-1:0] FREE_MIN_V = FREE_W'(FREE_MIN);
  localparam logic [FREE_W-1:0] FREE_MAX_V = FREE_W'(FREE_MAX);

  logic [PIE_W-1:0]  pie_q, pie_d;
  logic [FREE_W-1:0] free_q, free_d;
  logic              cfg_q, adj_en;

  assign adj_en = (mode_q == MODE_POP);

  // Opposing events on one register cancel; defaults beats everything.
  always_comb begin
    pie_d  = pie_q;
    free_d = free_q;
    if (btn_press[BTN_DEF]) begin
      pie_d  = PIE_DEF_V;
      free_d = FREE_DEF_V;
    end else if (adj_en) begin
      if (btn_evt[BTN_TL] && !btn_evt[BTN_BL] && pie_q < PIE_MAX_V)
        pie_d = pie_q + 1'b1;
      else if (btn_evt[BTN_BL] && !btn_evt[BTN_TL] && pie_q > PIE_MIN_V)
        pie_d = pie_q - 1'b1;
      if (btn_evt[BTN_TR] && !btn_evt[BTN_BR] && free_q < FREE_MAX_V)
        free_d = free_q + 1'b1;
      else if (btn_evt[BTN_BR] && !btn_evt[BTN_TR] && free_q > FREE_MIN_V)
        free_d = free_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pie_q  <= PIE_DEF_V;
      free_q <= FREE_DEF_V;
      cfg_q  <= 1'b0;
    end else begin
      pie_q  <= pie_d;
      free_q <= free_d;
      cfg_q  <= (pie_d != pie_q) || (free_d != free_q);
    end
  end

  // ---------------- output pins ----------------
  pins_t pins_d, pins_q;

  always_comb begin
    pins_d = '0;
    unique case (mode_q)
      MODE_LASER_SETUP: begin
        pins_d.led    = bus.slow_pulse;
        pins_d.probe  = 1'b1;
        pins_d.sample = 1'b1;
      end
      MODE_POP: begin
        pins_d.led    = 1'b1;
        pins_d.pump   = bus.pump_in;
        pins_d.probe  = bus.probe_in;
        pins_d.mw     = bus.mw_in;
        pins_d.sample = bus.sample_in;
      end
      MODE_DARK: begin
        pins_d.led    = bus.fast_pulse;
        pins_d.sample = 1'b1;
      end
      MODE_PUMP_CAL: begin
        pins_d.pump = 1'b1;
      end
      MODE_DR: begin
        pins_d.led    = bus.slow_pulse & bus.fast_pulse;
        pins_d.probe  = 1'b1;
        pins_d.mw     = 1'b1;
        pins_d.sample = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pins_q <= '0;
    else     pins_q <= pins_d;
  end

  assign bus.mode       = mode_q;
  assign bus.pie_len    = pie_q;
  assign bus.free_len   = free_q;
  assign bus.cfg_update = cfg_q;
  assign bus.led        = pins_q.led;
  assign bus.pump_out   = pins_q.pump;
  assign bus.probe_out  = pins_q.probe;
  assign bus.mw_out     = pins_q.mw;
  assign bus.sample_out = pins_q.sample;
endmodule

// File: tb/tb_pop_sequence_controller.sv
module tb_pop_sequence_controller;
  import pop_ctrl_pkg::*;

  typedef struct { int pie; int free; } regs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] btn_n = 6'b111111;

  int n_vec = 0;
  int n_err = 0;
  regs_t exp_reg_q[$];
  int    exp_mode_q[$];
  logic [2:0] prev_mode = '0;

  always #5 clk = ~clk;

  pop_ctrl_if #(.PIE_W(8), .FREE_W(12)) bus ();

  assign bus.mode_btn_n     = btn_n[BTN_MODE];
  assign bus.defaults_btn_n = btn_n[BTN_DEF];
  assign bus.tl_btn_n       = btn_n[BTN_TL];
  assign bus.tr_btn_n       = btn_n[BTN_TR];
  assign bus.bl_btn_n       = btn_n[BTN_BL];
  assign bus.br_btn_n       = btn_n[BTN_BR];

  pop_sequence_controller #(
    .DEB_COUNT(4),
    .REPEAT_TICKS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cfg_update pops the expected register pair, every
  // mode change pops the expected mode.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cfg_update) begin
        if (exp_reg_q.size() == 0) chk("cfg_unexpected", bus.cfg_update, 0);
        else begin
          regs_t r;
          r = exp_reg_q.pop_front();
          chk("cfg_pie", bus.pie_len, r.pie);
          chk("cfg_free", bus.free_len, r.free);
        end
      end
      if (bus.mode != prev_mode) begin
        if (exp_mode_q.size() == 0) chk("mode_unexpected", bus.mode, prev_mode);
        else chk("mode_step", bus.mode, exp_mode_q.pop_front());
      end
    end
    prev_mode = bus.mode;
  end

  task automatic ticks(input int n);
    repeat (n) begin
      repeat (3) @(posedge clk);
      #1 bus.tick_100us = 1'b1;
      @(posedge clk);
      #1 bus.tick_100us = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic hold(input int idx, input int n);
    btn_n[idx] = 1'b0;
    ticks(n);
    btn_n[idx] = 1'b1;
    ticks(6);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.tick_100us = 1'b0;
    bus.pump_in = 1'b0; bus.probe_in = 1'b0; bus.mw_in = 1'b0; bus.sample_in = 1'b0;
    bus.slow_pulse = 1'b1; bus.fast_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_mode", bus.mode, 0);
    chk("rst_pie", bus.pie_len, 25);
    chk("rst_free", bus.free_len, 250);
    chk("rst_cfg", bus.cfg_update, 0);
    chk("rst_pins", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b00000);
    rst = 1'b0;
    settle();
    chk("m0_pins", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b10101);
    bus.slow_pulse = 1'b0;
    settle();
    chk("m0_led_slow", bus.led, 0);

    // short press rejected
    hold(BTN_MODE, 3);
    chk("short_press", bus.mode, 0);

    // accepted press -> mode 1
    exp_mode_q.push_back(1);
    hold(BTN_MODE, 4);
    chk("mode_to_pop", bus.mode, 1);
    bus.pump_in = 1'b1;
    settle();
    chk("m1_pins", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b11000);
    bus.pump_in = 1'b0;

    // auto-repeat on tl: 26 at accept, 27 at +8, then every 2 ticks
    for (int v = 26; v <= 30; v++) exp_reg_q.push_back('{v, 250});
    hold(BTN_TL, 16);
    chk("rpt_pie", bus.pie_len, 30);
    chk("rpt_queue", exp_reg_q.size(), 0);

    // drive pie to 255 and hold past saturation
    for (int v = 31; v <= 255; v++) exp_reg_q.push_back('{v, 250});
    hold(BTN_TL, 470);
    chk("sat_pie_max", bus.pie_len, 255);
    hold(BTN_TL, 4);
    chk("sat_pie_again", bus.pie_len, 255);

    // drive free to 1 and past
    for (int v = 249; v >= 1; v--) exp_reg_q.push_back('{255, v});
    hold(BTN_BR, 520);
    chk("sat_free_min", bus.free_len, 1);
    hold(BTN_BR, 4);
    chk("sat_free_again", bus.free_len, 1);

    // defaults overrides tl+bl
    exp_reg_q.push_back('{25, 250});
    btn_n[BTN_TL] = 1'b0; btn_n[BTN_BL] = 1'b0; btn_n[BTN_DEF] = 1'b0;
    ticks(4);
    btn_n = 6'b111111;
    ticks(6);
    chk("def_pie", bus.pie_len, 25);
    chk("def_free", bus.free_len, 250);

    // tl+bl cancel
    btn_n[BTN_TL] = 1'b0; btn_n[BTN_BL] = 1'b0;
    ticks(4);
    btn_n = 6'b111111;
    ticks(6);
    chk("cancel_pie", bus.pie_len, 25);

    // tl+br on different registers both apply, one pulse
    exp_reg_q.push_back('{26, 249});
    btn_n[BTN_TL] = 1'b0; btn_n[BTN_BR] = 1'b0;
    ticks(4);
    btn_n = 6'b111111;
    ticks(6);
    chk("both_pie", bus.pie_len, 26);
    chk("both_free", bus.free_len, 249);

    // leaving mode 1 while the timer is busy
    bus.sample_in = 1'b1;
    settle();
    chk("m1_sample_pass", bus.sample_out, 1);
    exp_mode_q.push_back(2);
    hold(BTN_MODE, 4);
`ifdef POP_CYCLE_SYNC_EN
    chk("sync_pending", bus.mode, 1);
    bus.sample_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sync_commit", bus.mode, 2);
`else
    chk("nosync_commit", bus.mode, 2);
    bus.sample_in = 1'b0;
`endif

    // mode 2: adjust dropped, pin mux
    hold(BTN_TL, 4);
    chk("m2_drop", bus.pie_len, 26);
    bus.fast_pulse = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("m2_pins", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b10001);

    // mode 3: defaults honoured outside mode 1
    exp_mode_q.push_back(3);
    hold(BTN_MODE, 4);
    chk("m3_pins", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b01000);
    exp_reg_q.push_back('{25, 250});
    hold(BTN_DEF, 4);
    chk("m3_def_pie", bus.pie_len, 25);
    chk("m3_def_free", bus.free_len, 250);

    // mode 4 led = slow & fast
    exp_mode_q.push_back(4);
    hold(BTN_MODE, 4);
    chk("m4_pins_lo", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b00111);
    bus.slow_pulse = 1'b1;
    settle();
    chk("m4_led_hi", bus.led, 1);

    // fifth press wraps to 0
    exp_mode_q.push_back(0);
    hold(BTN_MODE, 4);
    chk("wrap_mode", bus.mode, 0);

    // reset mid-debounce: partial count is discarded
    btn_n[BTN_MODE] = 1'b0;
    ticks(2);
    rst = 1'b1;
    settle();
    btn_n[BTN_MODE] = 1'b1;
    settle();
    chk("midrst_pins", {bus.led, bus.pump_out, bus.probe_out, bus.mw_out, bus.sample_out}, 5'b00000);
    rst = 1'b0;
    hold(BTN_MODE, 2);
    chk("midrst_mode", bus.mode, 0);

    chk("reg_queue_empty", exp_reg_q.size(), 0);
    chk("mode_queue_empty", exp_mode_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pop_sequence_controller.md
Name: pop_sequence_controller

Overview:
Front-panel and mode controller for the POP timing chain. It debounces the six active-low push buttons and runs the five-mode operating state machine. It owns the two POP timing registers (pi/2 pulse length, free-precession length) that configure the POP timer block. It also drives the registered LED/pump/probe/MW/sample output pins from the mode and the timer's raw signals. It replaces the separate button sampling, mode machines and output mux at top level.

Parameters:
PIE_W, 8, width of pi/2 length register (clk cycles)
FREE_W, 12, width of free-precession length register
PIE_DEFAULT, 25, pi/2 length after reset/load-defaults
FREE_DEFAULT, 250, free-precession length after reset/load-defaults
PIE_MIN / PIE_MAX, 1 / 255, saturation limits for pi/2 length
FREE_MIN / FREE_MAX, 1 / 4095, saturation limits for free-precession length
DEB_COUNT, 4, consecutive ticks a raw level must hold to be accepted
REPEAT_TICKS, 2000, hold time (ticks) before auto-repeat; repeat period = REPEAT_TICKS/4

Ports:
clk  in  1  2.5 MHz system clock
rst  in  1  synchronous reset, active-high
tick_100us  in  1  one-cycle strobe every 100 us (debounce pulse)
mode_btn_n, defaults_btn_n, tl_btn_n, tr_btn_n, bl_btn_n, br_btn_n  in  1 each  raw buttons, low = pressed
pump_in, probe_in, mw_in, sample_in  in  1 each  raw POP timer outputs
slow_pulse, fast_pulse  in  1 each  LED blink sources
mode  out  3  current mode 0..4
pie_len  out  PIE_W  pi/2 length to POP timer
free_len  out  FREE_W  free-precession length to POP timer
cfg_update  out  1  one-cycle pulse after pie_len/free_len changes value
led, pump_out, probe_out, mw_out, sample_out  out  1 each  registered pin drivers

Behaviour:
- Reset values: mode=0, pie_len=PIE_DEFAULT, free_len=FREE_DEFAULT, cfg_update=0, all pin outputs 0. All debouncers hold "released", all repeat counters hold 0.
- Debounce, per button: the raw level is sampled only on tick_100us. The debounced state flips after DEB_COUNT consecutive ticks at the new level. Any differing sample restarts the count.
- Press event: one clk pulse on the debounced released->pressed transition.
- Auto-repeat applies to tl/tr/bl/br only. While held, an extra press event fires at REPEAT_TICKS ticks after the accepted press, then every REPEAT_TICKS/4 ticks. It stops when the button is released.
- Mode FSM: each mode press steps 0->1->2->3->4->0. Modes are LASER_SETUP, POP, DARK, PUMP_CAL, DR.
- Register adjust is honoured only in mode 1; events in other modes are dropped.
  - tl: pie_len+1; bl: pie_len-1.
  - tr: free_len+1; br: free_len-1.
  - Saturate at MIN/MAX; no wrap.
- Load defaults: honoured in any mode; writes both registers to their defaults.
- Simultaneous events:
  - Defaults overrides all +/- events that cycle.
  - + and - on the same register in the same cycle: no change.
  - Events on different registers both apply.
- cfg_update: asserted the cycle after the register edge, only if either value actually changed. Saturated or no-op writes do not pulse it.
- Output mux, registered, 1 clk latency from inputs/mode:
  - mode0: led=slow_pulse, probe=1, sample=1, others 0.
  - mode1: led=1, pump/probe/mw/sample pass through from *_in.
  - mode2: led=fast_pulse, sample=1, others 0.
  - mode3: led=0, pump=1, others 0.
  - mode4: led=slow_pulse&fast_pulse, probe=1, mw=1, sample=1, pump=0.
- Reset asserted mid-operation: all state returns to the reset values on the next edge, including a partially counted debounce or repeat.

Optional Feature:
POP_CYCLE_SYNC_EN.
- Defined: a mode press that enters or leaves mode 1 is held pending. It commits on the first clk where pump_in, probe_in, mw_in and sample_in are all 0, so no timer pulse is truncated. Further mode presses while pending are ignored. Transitions not touching mode 1 commit immediately.
- Undefined: every mode press commits on the next edge.

Decomposition:
- Package pop_ctrl_pkg:
  - mode encodings MODE_LASER_SETUP=0, MODE_POP=1, MODE_DARK=2, MODE_PUMP_CAL=3, MODE_DR=4;
  - MODE_W=3;
  - default widths/limits as constants.
- Sub-module button_debounce: raw_n, tick, outputs pressed level, press pulse and repeat pulse, with a repeat-enable parameter. Instantiated six times.

Test Plan (DEB_COUNT=4, REPEAT_TICKS=8):
- Reset then release: mode=0, pie_len=25, free_len=250. One clk later probe_out=1, sample_out=1, led follows slow_pulse.
- mode_btn_n low for 3 ticks then high: no mode change. Low for 4 ticks: mode 0->1 exactly once. Five accepted presses return to 0.
- Mode 1, hold tl_btn_n 16 ticks: pie_len 25->26 at accept, 27 at +8 ticks, then +1 every 2 ticks, reaching 30. One cfg_update per change.
- Mode 1, pie_len=255, press tl: stays 255, no cfg_update. free_len=1, press br: stays 1.
- Mode 1, press tl and bl in the same tick with defaults_btn_n pressed: pie_len=25, free_len=250. Tl+bl without defaults: no change.
- POP_CYCLE_SYNC_EN, mode 1, mode press while sample_in=1: mode stays 1 until the first cycle all *_in=0, then 2. Undefined build: mode=2 on the next edge.
